lfsr_stream_cipher: RTL and testbench

- Hardware LFSR stream-cipher engine that performs the encrypt and decrypt programs of the message-encryption flow without software.
- Encrypt mode frames a plaintext message with a space preamble and trailing space padding, then XORs every byte with an LFSR keystream.
- Decrypt mode recovers seed and tap pattern from the known space preamble, then emits the message with leading spaces stripped.
- Sits between the data-memory streaming front end and the processor as a memory-mapped accelerator, using valid/ready streams on both sides.

---
 rtl/lfsr_stream_cipher.sv | 243 ++++++++++++++++++++++++
 tb/tb_lfsr_stream_cipher.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_stream_cipher.sv
// LFSR stream-cipher engine.
// Encrypt: frames a message with a PAD preamble and PAD tail, then XORs the frame with an LFSR keystream.
// Decrypt: recovers the seed and tap mask from the PAD preamble, then emits plaintext with leading PAD stripped.
module lfsr_stream_cipher #(
    parameter int           W         = 8,
    parameter int           FRAME_LEN = 64,
    parameter int           MSG_LEN   = 41,
    parameter int           NUM_PTRN  = 8,
    parameter int           DET_LEN   = 8,
    parameter logic [W-1:0] PAD       = 8'h20
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           mode,
    input  logic [$clog2(FRAME_LEN+1)-1:0] pre_len,
    input  logic [W-1:0]                   taps,
    input  logic [W-1:0]                   seed,
    input  logic [NUM_PTRN*W-1:0]          cand_taps,
    input  logic [W-1:0]                   s_data,
    input  logic                           s_valid,
    output logic                           s_ready,
    output logic [W-1:0]                   m_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic                           m_last,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    output logic [$clog2(NUM_PTRN)-1:0]    found_idx,
    output logic [W-1:0]                   found_seed
);

    localparam int PW = $clog2(FRAME_LEN + 1);
    localparam int IW = $clog2(NUM_PTRN);

    typedef enum logic [2:0] {S_IDLE, S_ENC, S_DET, S_DEC, S_DONE} state_t;

    // One LFSR step: shift left, feedback is the parity of the tapped bits.
    function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s, input logic [W-1:0] t);
        return {s[W-2:0], ^(s & t)};
    endfunction

    state_t           state_r, state_s;
    logic [PW-1:0]    pre_len_r, pos_r;
    logic [W-1:0]     taps_r, lfsr_r;
    logic             seen_r;
    logic [NUM_PTRN-1:0] alive_r;
    logic [W-1:0]     cand_r [NUM_PTRN];
    logic             busy_r, done_r, err_r;
    logic [IW-1:0]    found_idx_r;
    logic [W-1:0]     found_seed_r;
    logic             m_valid_r, m_last_r;
    logic [W-1:0]     m_data_r;

    logic             out_free_s, last_pos_s, det_last_s, in_msg_s, start_ok_s;
    logic             s_ready_s, take_s, emit_s, emit_last_s;
    logic [W-1:0]     emit_data_s, key_s;
    logic [W-1:0]     ctap_s [NUM_PTRN];
    logic [NUM_PTRN-1:0] cand_ok_s;
    logic             any_ok_s;
    logic [IW-1:0]    sel_s;

    assign out_free_s = !m_valid_r || m_ready;
    assign last_pos_s = (pos_r == PW'(FRAME_LEN - 1));
    assign det_last_s = (pos_r == PW'(DET_LEN - 1));
    assign in_msg_s   = (int'(pos_r) >= int'(pre_len_r)) && (int'(pos_r) < int'(pre_len_r) + MSG_LEN);
    assign start_ok_s = start && ((state_r == S_IDLE) || (state_r == S_DONE));

    // Compare the recovered keystream byte with every live candidate; pick the lowest match.
    always_comb begin
        key_s = s_data ^ PAD;
        sel_s = {IW{1'b0}};
        for (int j = 0; j < NUM_PTRN; j++) begin
            ctap_s[j]    = cand_taps[j*W +: W];
            cand_ok_s[j] = alive_r[j] && (key_s == cand_r[j]);
        end
        any_ok_s = |cand_ok_s;
        for (int j = NUM_PTRN - 1; j >= 0; j--) begin
            sel_s = cand_ok_s[j] ? IW'(j) : sel_s;
        end
    end

    // Next-state decode, input handshake and selection of the byte to produce.
    always_comb begin
        state_s     = state_r;
        s_ready_s   = 1'b0;
        take_s      = 1'b0;
        emit_s      = 1'b0;
        emit_data_s = {W{1'b0}};
        emit_last_s = 1'b0;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (start) state_s = mode ? S_DET : S_ENC;
                else       state_s = state_r;
            end
            S_ENC: begin
                if (in_msg_s) begin
                    s_ready_s   = out_free_s;
                    take_s      = s_valid && out_free_s;
                    emit_s      = take_s;
                    emit_data_s = s_data ^ lfsr_r;
                end else begin
                    emit_s      = out_free_s;
                    emit_data_s = PAD ^ lfsr_r;
                end
                emit_last_s = last_pos_s;
                if (emit_s && last_pos_s) state_s = S_DONE;
                else                      state_s = S_ENC;
            end
            S_DET: begin
                s_ready_s = 1'b1;
                take_s    = s_valid;
                if (take_s && det_last_s) state_s = any_ok_s ? S_DEC : S_DONE;
                else                      state_s = S_DET;
            end
            S_DEC: begin
                s_ready_s   = out_free_s;
                take_s      = s_valid && out_free_s;
                emit_data_s = s_data ^ lfsr_r;
                // Leading PAD bytes are swallowed until the first real character appears.
                emit_s      = take_s && (seen_r || (emit_data_s != PAD));
                emit_last_s = last_pos_s;
                if (take_s && last_pos_s) state_s = S_DONE;
                else                      state_s = S_DEC;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_r <= S_IDLE;
        else       state_r <= state_s;
    end

    // Operation context, keystream LFSR, detection bank and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_len_r    <= {PW{1'b0}};
            pos_r        <= {PW{1'b0}};
            taps_r       <= {W{1'b0}};
            lfsr_r       <= {W{1'b0}};
            seen_r       <= 1'b0;
            alive_r      <= {NUM_PTRN{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            found_idx_r  <= {IW{1'b0}};
            found_seed_r <= {W{1'b0}};
            for (int j = 0; j < NUM_PTRN; j++) cand_r[j] <= {W{1'b0}};
        end else if (start_ok_s) begin
            pre_len_r    <= pre_len;
            taps_r       <= taps;
            lfsr_r       <= seed;
            pos_r        <= {PW{1'b0}};
            seen_r       <= 1'b0;
            alive_r      <= {NUM_PTRN{1'b1}};
            busy_r       <= 1'b1;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            found_idx_r  <= {IW{1'b0}};
            found_seed_r <= {W{1'b0}};
        end else begin
            case (state_r)
                S_ENC: begin
                    if (emit_s) begin
                        lfsr_r <= lfsr_step(lfsr_r, taps_r);
                        pos_r  <= pos_r + PW'(1);
                        if (last_pos_s) begin
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                        end
                    end
                end
                S_DET: begin
                    if (take_s) begin
                        pos_r <= pos_r + PW'(1);
                        if (pos_r == {PW{1'b0}}) begin
                            // First preamble byte reveals the seed; every candidate starts from it.
                            found_seed_r <= key_s;
                            for (int j = 0; j < NUM_PTRN; j++) cand_r[j] <= lfsr_step(key_s, ctap_s[j]);
                        end else begin
                            alive_r <= cand_ok_s;
                            for (int j = 0; j < NUM_PTRN; j++) cand_r[j] <= lfsr_step(cand_r[j], ctap_s[j]);
                            if (det_last_s) begin
                                if (any_ok_s) begin
                                    found_idx_r <= sel_s;
                                    taps_r      <= ctap_s[sel_s];
                                    lfsr_r      <= lfsr_step(cand_r[sel_s], ctap_s[sel_s]);
                                end else begin
                                    err_r  <= 1'b1;
                                    done_r <= 1'b1;
                                    busy_r <= 1'b0;
                                end
                            end
                        end
                    end
                end
                S_DEC: begin
                    if (take_s) begin
                        lfsr_r <= lfsr_step(lfsr_r, taps_r);
                        pos_r  <= pos_r + PW'(1);
                        if (emit_s) seen_r <= 1'b1;
                        if (last_pos_s) begin
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output holding register: load a new byte, or empty once the consumer takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid_r <= 1'b0;
            m_data_r  <= {W{1'b0}};
            m_last_r  <= 1'b0;
        end else if (emit_s) begin
            m_valid_r <= 1'b1;
            m_data_r  <= emit_data_s;
            m_last_r  <= emit_last_s;
        end else if (m_valid_r && m_ready) begin
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
        end
    end

    assign s_ready    = s_ready_s;
    assign m_data     = m_data_r;
    assign m_valid    = m_valid_r;
    assign m_last     = m_last_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;
    assign found_idx  = found_idx_r;
    assign found_seed = found_seed_r;

endmodule

// File: tb/tb_lfsr_stream_cipher.sv
// Self-checking bench for lfsr_stream_cipher with a behavioural keystream/framing model.
module tb_lfsr_stream_cipher;

    localparam int W  = 8;
    localparam int FL = 64;
    localparam int ML = 41;
    localparam int NP = 8;
    localparam int DL = 8;
    localparam logic [7:0] SP = 8'h20;

    logic           clk = 1'b0;
    logic           reset = 1'b1, start = 1'b0, mode = 1'b0;
    logic [6:0]     pre_len = 7'd0;
    logic [7:0]     taps = 8'h00, seed = 8'h00;
    logic [NP*W-1:0] cand_taps;
    logic [7:0]     s_data = 8'h00;
    logic           s_valid = 1'b0, s_ready;
    logic [7:0]     m_data;
    logic           m_valid, m_ready = 1'b0, m_last;
    logic           busy, done, err;
    logic [2:0]     found_idx;
    logic [7:0]     found_seed;

    always #5 clk = ~clk;

    lfsr_stream_cipher dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .pre_len(pre_len),
        .taps(taps), .seed(seed), .cand_taps(cand_taps), .s_data(s_data),
        .s_valid(s_valid), .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last), .busy(busy), .done(done), .err(err),
        .found_idx(found_idx), .found_seed(found_seed)
    );

    int          total = 0, bad = 0;
    logic [7:0]  frame [FL];
    logic [7:0]  src [FL];
    int          src_n;
    logic [7:0]  ctaps [NP];
    logic [7:0]  outq [$];
    logic        lastq [$];
    logic [7:0]  expq [$];
    int          consumed;
    bit          saw_valid;
    int          exp_idx;
    logic [7:0]  exp_seed;
    bit          exp_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Keystream successor computed arithmetically: doubling drops into the next state, plus tap parity.
    function automatic logic [7:0] ks_next(input logic [7:0] s, input logic [7:0] t);
        int ones;
        int v;
        ones = 0;
        for (int b = 0; b < 8; b++) if (s[b] && t[b]) ones++;
        v = (int'(s) * 2 + (ones % 2)) % 256;
        return v[7:0];
    endfunction

    task automatic model_encrypt(input logic [7:0] sd, input logic [7:0] tp, input int pre, input string msg);
        logic [7:0] st;
        logic [7:0] pl;
        st = sd;
        expq.delete();
        for (int p = 0; p < FL; p++) begin
            if (p >= pre && p < pre + ML) pl = msg[p - pre];
            else                          pl = SP;
            frame[p] = pl ^ st;
            expq.push_back(frame[p]);
            st = ks_next(st, tp);
        end
    endtask

    task automatic model_decrypt();
        logic [7:0] st;
        logic [7:0] d;
        bit ok;
        bit lead;
        exp_seed = frame[0] ^ SP;
        exp_err  = 1'b1;
        exp_idx  = 0;
        for (int j = NP - 1; j >= 0; j--) begin
            st = exp_seed;
            ok = 1'b1;
            for (int i = 0; i < DL; i++) begin
                if ((frame[i] ^ SP) != st) ok = 1'b0;
                st = ks_next(st, ctaps[j]);
            end
            if (ok) begin
                exp_idx = j;
                exp_err = 1'b0;
            end
        end
        expq.delete();
        if (!exp_err) begin
            st = exp_seed;
            lead = 1'b1;
            for (int p = 0; p < FL; p++) begin
                d = frame[p] ^ st;
                st = ks_next(st, ctaps[exp_idx]);
                if (d != SP) lead = 1'b0;
                if (!lead) expq.push_back(d);
            end
        end
    endtask

    task automatic load_msg(input string msg);
        for (int i = 0; i < ML; i++) src[i] = msg[i];
        src_n = ML;
    endtask

    task automatic load_frame();
        for (int i = 0; i < FL; i++) src[i] = frame[i];
        src_n = FL;
    endtask

    task automatic do_start(input bit md, input logic [7:0] sd, input logic [7:0] tp, input int pre);
        @(negedge clk);
        mode    = md;
        seed    = sd;
        taps    = tp;
        pre_len = 7'(pre);
        s_valid = 1'b0;
        m_ready = 1'b0;
        start   = 1'b1;
    endtask

    // Drives one operation to completion, capturing outputs and checking stall stability.
    task automatic run_op(input bit rv, input bit tr, input int abort_at, input bit poke);
        bit         held;
        logic [7:0] held_d;
        bit         fin;
        int         cyc;
        consumed  = 0;
        saw_valid = 1'b0;
        held      = 1'b0;
        held_d    = 8'h00;
        fin       = 1'b0;
        cyc       = 0;
        outq.delete();
        lastq.delete();
        while (!fin && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start = poke && (cyc == 10);
            if (start) begin
                mode    = ~mode;
                seed    = 8'($urandom);
                pre_len = 7'd0;
            end
            m_ready = tr ? cyc[0] : 1'b1;
            s_valid = rv ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = (consumed < src_n) ? src[consumed] : 8'($urandom);
            #1;
            if (m_valid) saw_valid = 1'b1;
            if (held) begin
                check("stall_valid", 32'(m_valid), 32'd1);
                check("stall_data", 32'(m_data), 32'(held_d));
            end
            held   = m_valid && !m_ready;
            held_d = m_data;
            if (s_valid && s_ready) consumed++;
            if (m_valid && m_ready) begin
                outq.push_back(m_data);
                lastq.push_back(m_last);
                if (abort_at > 0 && outq.size() == abort_at) return;
            end
            if (done && !m_valid) fin = 1'b1;
        end
        check("op_finished", 32'(fin), 32'd1);
    endtask

    task automatic cmp_out(input string tag);
        int n;
        check({tag, "_count"}, 32'(outq.size()), 32'(expq.size()));
        n = (outq.size() < expq.size()) ? outq.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_byte%0d", tag, i), 32'(outq[i]), 32'(expq[i]));
            check($sformatf("%s_last%0d", tag, i), 32'(lastq[i]), (i == expq.size() - 1) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        string m_watson;
        string m_know;
        string m_joke;
        int    k;
        logic [7:0] sd;
        logic [7:0] tp;
        int    pre;

        m_watson = "Mr. Watson, come here. I want to see you.";
        m_know   = "Knowledge comes, but wisdom lingers.     ";
        m_joke   = "    f     A joke a day keeps doctors away";
        ctaps[0] = 8'he1; ctaps[1] = 8'h8e; ctaps[2] = 8'h96; ctaps[3] = 8'hb8;
        ctaps[4] = 8'h1d; ctaps[5] = 8'hfa; ctaps[6] = 8'h71; ctaps[7] = 8'hc3;
        for (int j = 0; j < NP; j++) cand_taps[j*W +: W] = ctaps[j];

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_found_idx", 32'(found_idx), 32'd0);
        check("rst_found_seed", 32'(found_seed), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        reset = 1'b0;

        // Encrypt the reference message
        load_msg(m_watson);
        model_encrypt(8'h01, 8'he1, 9, m_watson);
        do_start(1'b0, 8'h01, 8'he1, 9);
        run_op(1'b0, 1'b0, 0, 1'b0);
        cmp_out("enc");
        if (outq.size() >= 2) begin
            check("enc_b0", 32'(outq[0]), 32'h21);
            check("enc_b1", 32'(outq[1]), 32'h23);
        end
        check("enc_consumed", 32'(consumed), 32'd41);
        check("enc_done", 32'(done), 32'd1);
        check("enc_busy", 32'(busy), 32'd0);

        // Decrypt a known frame (candidate 3)
        model_encrypt(8'h35, 8'hb8, 9, m_know);
        model_decrypt();
        load_frame();
        do_start(1'b1, 8'h00, 8'h00, 0);
        run_op(1'b1, 1'b0, 0, 1'b0);
        check("dec_idx", 32'(found_idx), 32'd3);
        check("dec_seed", 32'(found_seed), 32'h35);
        check("dec_err", 32'(err), 32'd0);
        check("dec_n55", 32'(outq.size()), 32'd55);
        cmp_out("dec");

        // Decrypt with leading message spaces, random seed and candidate
        k  = $urandom_range(0, NP - 1);
        sd = 8'h01;
        for (int t = 0; t < 50; t++) begin
            sd = 8'($urandom_range(1, 255));
            model_encrypt(sd, ctaps[k], 13, m_joke);
            model_decrypt();
            if (exp_idx == k) break;
        end
        load_frame();
        do_start(1'b1, 8'h00, 8'h00, 0);
        run_op(1'b1, 1'b1, 0, 1'b0);
        check("lead_idx", 32'(found_idx), 32'(k));
        check("lead_seed", 32'(found_seed), 32'(sd));
        check("lead_n47", 32'(outq.size()), 32'd47);
        if (outq.size() > 0) check("lead_first", 32'(outq[0]), 32'h66);
        cmp_out("lead");

        // Corrupted c1: detection must fail
        model_encrypt(8'h35, 8'hb8, 9, m_know);
        frame[1] = frame[1] ^ 8'h80;
        model_decrypt();
        load_frame();
        do_start(1'b1, 8'h00, 8'h00, 0);
        run_op(1'b0, 1'b0, 0, 1'b0);
        check("bad_err", 32'(err), 32'd1);
        check("bad_done", 32'(done), 32'd1);
        check("bad_no_valid", 32'(saw_valid), 32'd0);
        check("bad_count", 32'(outq.size()), 32'd0);

        // Backpressure encrypt with random seed/taps/preamble
        sd  = 8'($urandom);
        tp  = 8'($urandom);
        pre = $urandom_range(0, 23);
        load_msg(m_watson);
        model_encrypt(sd, tp, pre, m_watson);
        do_start(1'b0, sd, tp, pre);
        run_op(1'b1, 1'b1, 0, 1'b0);
        cmp_out("bp");

        // Abort mid-frame with reset
        do_start(1'b0, sd, tp, pre);
        run_op(1'b1, 1'b1, 20, 1'b0);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        #1;
        check("abort_m_valid", 32'(m_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        reset = 1'b0;
        model_encrypt(8'h01, 8'he1, 9, m_watson);
        do_start(1'b0, 8'h01, 8'he1, 9);
        run_op(1'b1, 1'b0, 0, 1'b0);
        cmp_out("fresh");

        // Long preamble: only 4 message bytes fit; a start pulse while busy is ignored
        sd = 8'($urandom);
        tp = 8'($urandom);
        model_encrypt(sd, tp, 60, m_watson);
        do_start(1'b0, sd, tp, 60);
        run_op(1'b1, 1'b1, 0, 1'b1);
        check("p60_consumed", 32'(consumed), 32'd4);
        cmp_out("p60");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
